// File: rtl/gcn_vec_mult_array_pkg.sv
// Shared types, defaults and fixed-point helpers for the GCN vector multiplier.
// Arithmetic helpers work on 64-bit signed values; callers slice the result.
package gcn_pkg;

   typedef enum logic {
      MODE_ELEM = 1'b0,
      MODE_DOT  = 1'b1
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } pkt_state_e;

   typedef struct packed {
      logic  v;
      mode_e mode;
      logic  last;
   } ctrl_t;

   localparam int DEF_LANES     = 25;
   localparam int DEF_DW        = 16;
   localparam int DEF_FRAC      = 8;
   localparam int DEF_ACC_GUARD = 8;

   function automatic int acc_width(input int lanes, input int dw, input int guard);
      return 2 * dw + $clog2(lanes) + guard;
   endfunction

   // Floor rescale: arithmetic shift rounds toward minus infinity.
   function automatic logic signed [63:0] shr_floor(input logic signed [63:0] x, input int sh);
      return x >>> sh;
   endfunction

   // Clamp to the signed range of a w-bit word.
   function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/gcn_vec_mult_array_if.sv
// Streaming valid/ready bundle between feature buffers, the multiplier and aggregation.
interface gcn_vec_mult_array_if
   import gcn_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int DW    = DEF_DW
);
   logic                in_v;
   logic                in_rdy;
   logic                in_mode;
   logic                in_last;
   logic [LANES*DW-1:0] in_fea;
   logic [LANES*DW-1:0] in_coef;
   logic                out_v;
   logic                out_rdy;
   logic [LANES*DW-1:0] out_data;
   logic                out_sat;

   modport master (
      output in_v, in_mode, in_last, in_fea, in_coef, out_rdy,
      input  in_rdy, out_v, out_data, out_sat
   );

   modport slave (
      input  in_v, in_mode, in_last, in_fea, in_coef, out_rdy,
      output in_rdy, out_v, out_data, out_sat
   );
endinterface

// File: rtl/gcn_vec_mult_array_lane_mult.sv
// One multiplier lane: operand register, full-width product, elementwise rescale+saturate.
module gcn_lane_mult
   import gcn_pkg::*;
#(
   parameter int DW   = DEF_DW,
   parameter int FRAC = DEF_FRAC
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic signed [DW-1:0]  fea_i,
   input  logic signed [DW-1:0]  coef_i,
   output logic signed [2*DW-1:0] prod_o,
   output logic [DW-1:0]         fmt_o,
   output logic                  sat_o
);
   logic signed [DW-1:0]   fea_q, fea_d, coef_q, coef_d;
   logic signed [2*DW-1:0] prod_q, prod_d;
   logic [DW-1:0]          fmt_q, fmt_d;
   logic                   sat_q, sat_d;
   logic signed [63:0]     shifted, clamped;

   always_comb begin
      shifted = shr_floor(64'(prod_q), FRAC);
      clamped = sat_w(shifted, DW);
      fea_d   = fea_q;
      coef_d  = coef_q;
      prod_d  = prod_q;
      fmt_d   = fmt_q;
      sat_d   = sat_q;
      if (en) begin
         fea_d  = fea_i;
         coef_d = coef_i;
         prod_d = (2*DW)'(fea_q) * (2*DW)'(coef_q);
         fmt_d  = clamped[DW-1:0];
         sat_d  = (clamped != shifted);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fea_q  <= '0;
         coef_q <= '0;
         prod_q <= '0;
         fmt_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         fea_q  <= fea_d;
         coef_q <= coef_d;
         prod_q <= prod_d;
         fmt_q  <= fmt_d;
         sat_q  <= sat_d;
      end
   end

   assign prod_o = prod_q;
   assign fmt_o  = fmt_q;
   assign sat_o  = sat_q;
endmodule

// File: rtl/gcn_vec_mult_array.sv
// LANES-wide fixed-point multiplier: elementwise products or packet-accumulated dot product.
// Four-stage stallable pipeline; the whole pipe freezes while the output is back-pressured.
module gcn_vec_mult_array
   import gcn_pkg::*;
#(
   parameter int LANES     = DEF_LANES,
   parameter int DW        = DEF_DW,
   parameter int FRAC      = DEF_FRAC,
   parameter int ACC_GUARD = DEF_ACC_GUARD
) (
   input logic clk,
   input logic rst,
   input logic clr,
   gcn_vec_mult_array_if.slave bus
);
   localparam int PW    = 2 * DW;
   localparam int SUM_W = PW + $clog2(LANES);
   localparam int ACC_W = acc_width(LANES, DW, ACC_GUARD);

   logic                    stall, adv, accept;
   mode_e                   eff_mode;
   logic signed [PW-1:0]    prod [LANES];
   logic [DW-1:0]           fmt [LANES];
   logic [LANES-1:0]        sat_vec;
   logic [LANES*DW-1:0]     fmt_vec;
   logic signed [SUM_W-1:0] tree;

   ctrl_t                   c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
   logic signed [SUM_W-1:0] sum3_q, sum3_d;
   logic                    in_pkt_q, in_pkt_d;
   pkt_state_e              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    pkt_sat_q, pkt_sat_d;
   logic                    out_v_q, out_v_d;
   logic [LANES*DW-1:0]     out_data_q, out_data_d;
   logic                    out_sat_q, out_sat_d;
   logic signed [63:0]      acc_sum, acc_clamp, dot_shift, dot_clamp;
   logic                    acc_hit;

   assign stall      = out_v_q && !bus.out_rdy;
   assign adv        = !stall;
   assign bus.in_rdy = adv;
   assign accept     = bus.in_v && adv;
   // Mid-packet beats are dot beats whatever in_mode says.
   assign eff_mode   = in_pkt_q ? MODE_DOT : mode_e'(bus.in_mode);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         gcn_lane_mult #(.DW(DW), .FRAC(FRAC)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (adv),
            .fea_i  (bus.in_fea[gi*DW +: DW]),
            .coef_i (bus.in_coef[gi*DW +: DW]),
            .prod_o (prod[gi]),
            .fmt_o  (fmt[gi]),
            .sat_o  (sat_vec[gi])
         );
         assign fmt_vec[gi*DW +: DW] = fmt[gi];
      end
   endgenerate

   always_comb begin
      tree = '0;
      for (int i = 0; i < LANES; i++) tree = tree + SUM_W'(prod[i]);
   end

   always_comb begin
      acc_sum   = ((state_q == ST_ACC) ? 64'(acc_q) : 64'sd0) + 64'(sum3_q);
      acc_clamp = sat_w(acc_sum, ACC_W);
      acc_hit   = (acc_clamp != acc_sum);
      dot_shift = shr_floor(acc_clamp, FRAC);
      dot_clamp = sat_w(dot_shift, DW);

      c1_d       = c1_q;
      c2_d       = c2_q;
      c3_d       = c3_q;
      sum3_d     = sum3_q;
      in_pkt_d   = in_pkt_q;
      state_d    = state_q;
      acc_d      = acc_q;
      pkt_sat_d  = pkt_sat_q;
      out_v_d    = out_v_q;
      out_data_d = out_data_q;
      out_sat_d  = out_sat_q;

      if (adv) begin
         c1_d   = '{v: accept, mode: eff_mode, last: bus.in_last};
         c2_d   = c1_q;
         c3_d   = c2_q;
         sum3_d = tree;
         if (accept && eff_mode == MODE_DOT) in_pkt_d = !bus.in_last;
         out_v_d = 1'b0;
         if (c3_q.v && c3_q.mode == MODE_ELEM) begin
            out_v_d    = 1'b1;
            out_data_d = fmt_vec;
            out_sat_d  = |sat_vec;
         end else if (c3_q.v && c3_q.last) begin
            out_v_d             = 1'b1;
            out_data_d          = '0;
            out_data_d[DW-1:0]  = dot_clamp[DW-1:0];
            out_sat_d           = pkt_sat_q | acc_hit | (dot_clamp != dot_shift);
            acc_d               = '0;
            pkt_sat_d           = 1'b0;
            state_d             = ST_IDLE;
         end else if (c3_q.v) begin
            acc_d     = acc_clamp[ACC_W-1:0];
            pkt_sat_d = pkt_sat_q | acc_hit;
            state_d   = ST_ACC;
         end
      end

      // Flush wins over both a new accept and a held output.
      if (clr) begin
         c1_d.v    = 1'b0;
         c2_d.v    = 1'b0;
         c3_d.v    = 1'b0;
         in_pkt_d  = 1'b0;
         state_d   = ST_IDLE;
         acc_d     = '0;
         pkt_sat_d = 1'b0;
         out_v_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c1_q       <= '0;
         c2_q       <= '0;
         c3_q       <= '0;
         sum3_q     <= '0;
         in_pkt_q   <= 1'b0;
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         pkt_sat_q  <= 1'b0;
         out_v_q    <= 1'b0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else begin
         c1_q       <= c1_d;
         c2_q       <= c2_d;
         c3_q       <= c3_d;
         sum3_q     <= sum3_d;
         in_pkt_q   <= in_pkt_d;
         state_q    <= state_d;
         acc_q      <= acc_d;
         pkt_sat_q  <= pkt_sat_d;
         out_v_q    <= out_v_d;
         out_data_q <= out_data_d;
         out_sat_q  <= out_sat_d;
      end
   end

   assign bus.out_v    = out_v_q;
   assign bus.out_data = out_data_q;
   assign bus.out_sat  = out_sat_q;
endmodule

// File: tb/tb_gcn_vec_mult_array.sv
// Directed bench for gcn_vec_mult_array: elementwise, saturation, dot packets,
// back-pressure, asynchronous reset mid-packet and flush.
module tb_gcn_vec_mult_array;
   localparam int LANES = 25;
   localparam int DW    = 16;
   localparam int VW    = LANES * DW;

   logic clk;
   logic rst;
   logic clr;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [VW-1:0] rxq[$];

   gcn_vec_mult_array_if #(.LANES(LANES), .DW(DW)) bus ();

   gcn_vec_mult_array #(.LANES(LANES), .DW(DW), .FRAC(8), .ACC_GUARD(8)) dut (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] one_lane(input int lane, input logic [DW-1:0] v);
      logic [VW-1:0] r;
      r = '0;
      r[lane*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
      logic [VW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
      return r;
   endfunction

   // Output monitor: a transfer happens on the next rising edge when out_v && out_rdy.
   always @(negedge clk) begin
      #2;
      if (rst && bus.out_v && bus.out_rdy) begin
         rxq.push_back(bus.out_data);
         $display("xfer lane0=%h lane1=%h lane2=%h sat=%0b", bus.out_data[15:0],
                  bus.out_data[31:16], bus.out_data[47:32], bus.out_sat);
      end
   end

   task automatic send(input logic mode, input logic last, input logic [VW-1:0] fea,
                       input logic [VW-1:0] coef);
      int waited = 0;
      @(negedge clk);
      bus.in_v    = 1'b1;
      bus.in_mode = mode;
      bus.in_last = last;
      bus.in_fea  = fea;
      bus.in_coef = coef;
      #1;
      while (!bus.in_rdy && waited < 100) begin
         @(negedge clk);
         #1;
         waited++;
      end
      check("send_rdy", bus.in_rdy, 1'b1);
      @(posedge clk);
      #1;
      bus.in_v = 1'b0;
      $display("beat mode=%0b last=%0b lane0 fea=%h coef=%h", mode, last, fea[15:0], coef[15:0]);
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      @(negedge clk);
      while (!bus.out_v && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(tag, bus.out_v, 1'b1);
   endtask

   initial begin
      logic [VW-1:0] exp_v;
      logic [VW-1:0] held;
      int            seen;
      int            n;

      rst         = 1'b0;
      clr         = 1'b0;
      bus.in_v    = 1'b0;
      bus.in_mode = 1'b0;
      bus.in_last = 1'b0;
      bus.in_fea  = '0;
      bus.in_coef = '0;
      bus.out_rdy = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_v", bus.out_v, 1'b0);
      check("rst_out_data", bus.out_data, '0);
      check("rst_out_sat", bus.out_sat, 1'b0);
      check("rst_in_rdy", bus.in_rdy, 1'b1);
      @(negedge clk);
      rst = 1'b1;

      // Elementwise 2.0 * 1.5 = 3.0; result on the fourth rising edge counting the accept edge.
      send(1'b0, 1'b0, one_lane(0, 16'h0200), one_lane(0, 16'h0180));
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check($sformatf("elem_latency_gap%0d", c), bus.out_v, 1'b0);
      end
      @(negedge clk);
      check("elem_out_v", bus.out_v, 1'b1);
      check("elem_data", bus.out_data, one_lane(0, 16'h0300));
      check("elem_sat", bus.out_sat, 1'b0);

      // Saturation positive, negative, and an exact negative in-range value.
      send(1'b0, 1'b0,
           one_lane(0, 16'h7FFF) | one_lane(1, 16'h8000) | one_lane(2, 16'hFF00),
           one_lane(0, 16'h7FFF) | one_lane(1, 16'h7FFF) | one_lane(2, 16'h0100));
      wait_out("sat_out_v");
      exp_v = one_lane(0, 16'h7FFF) | one_lane(1, 16'h8000) | one_lane(2, 16'hFF00);
      check("sat_data", bus.out_data, exp_v);
      check("sat_flag", bus.out_sat, 1'b1);

      // Two-beat dot packet; second beat has in_mode=0 but must still count as dot.
      send(1'b1, 1'b0, fill(16'h0100), fill(16'h0100));
      send(1'b0, 1'b1, fill(16'h0100), fill(16'h0100));
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check($sformatf("dot_bubble%0d", c), bus.out_v, 1'b0);
      end
      @(negedge clk);
      check("dot_out_v", bus.out_v, 1'b1);
      check("dot_data", bus.out_data, one_lane(0, 16'h3200));
      check("dot_sat", bus.out_sat, 1'b0);

      // Back-pressure: six elementwise beats, out_rdy low for five cycles once out_v rises.
      @(negedge clk);
      rxq.delete();
      fork
         begin
            for (int k = 1; k <= 6; k++)
               send(1'b0, 1'b0, one_lane(0, 16'(k * 256)) | one_lane(1, 16'(k)), fill(16'h0100));
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!bus.out_v && n < 50);
            bus.out_rdy = 1'b0;
            held = bus.out_data;
            for (int c = 0; c < 5; c++) begin
               #1;
               check("bp_in_rdy_low", bus.in_rdy, 1'b0);
               check("bp_data_stable", bus.out_data, held);
               @(negedge clk);
            end
            bus.out_rdy = 1'b1;
         end
      join
      n = 0;
      while (rxq.size() < 6 && n < 60) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      check("bp_count", rxq.size(), 6);
      for (int i = 0; i < 6; i++) begin
         exp_v = one_lane(0, 16'((i + 1) * 256)) | one_lane(1, 16'(i + 1));
         check($sformatf("bp_beat%0d", i), (i < rxq.size()) ? rxq[i] : '0, exp_v);
      end

      // Asynchronous reset with a dot packet half-accumulated.
      send(1'b1, 1'b0, fill(16'h0100), fill(16'h0100));
      #2;
      rst = 1'b0;
      #1;
      check("arst_out_v", bus.out_v, 1'b0);
      check("arst_out_data", bus.out_data, '0);
      check("arst_out_sat", bus.out_sat, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      send(1'b1, 1'b1, fill(16'h0100), fill(16'h0100));
      wait_out("arst_new_out_v");
      check("arst_new_data", bus.out_data, one_lane(0, 16'h1900));

      // Flush coincident with an accepted beat while a packet is accumulating.
      send(1'b1, 1'b0, fill(16'h0100), fill(16'h0100));
      repeat (5) @(negedge clk);
      @(negedge clk);
      bus.in_v    = 1'b1;
      bus.in_mode = 1'b1;
      bus.in_last = 1'b1;
      bus.in_fea  = fill(16'h0100);
      bus.in_coef = fill(16'h0100);
      clr         = 1'b1;
      @(posedge clk);
      #1;
      bus.in_v = 1'b0;
      clr      = 1'b0;
      seen     = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_v) seen++;
      end
      check("clr_beat_dropped", seen, 0);
      send(1'b1, 1'b1, fill(16'h0100), fill(16'h0100));
      wait_out("clr_fresh_out_v");
      check("clr_fresh_data", bus.out_data, one_lane(0, 16'h1900));

      // Flush with a stalled pending output and in_v high.
      @(negedge clk);
      bus.out_rdy = 1'b0;
      send(1'b0, 1'b0, one_lane(0, 16'h0100), one_lane(0, 16'h0100));
      wait_out("clr_pending_out_v");
      @(negedge clk);
      bus.in_v = 1'b1;
      clr      = 1'b1;
      @(posedge clk);
      #1;
      bus.in_v = 1'b0;
      clr      = 1'b0;
      check("clr_kills_pending", bus.out_v, 1'b0);
      rxq.delete();
      @(negedge clk);
      bus.out_rdy = 1'b1;
      send(1'b0, 1'b0, one_lane(0, 16'h0300), one_lane(0, 16'h0200));
      wait_out("clr_after_out_v");
      repeat (3) @(negedge clk);
      check("clr_after_count", rxq.size(), 1);
      check("clr_after_data", (rxq.size() > 0) ? rxq[0] : '0, one_lane(0, 16'h0600));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
